// File: rtl/addsub_pkg.sv
// Shared definitions for the 4-bit add/subtract result stage and its block accumulator.
package addsub_pkg;

    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } accum_state_e;

endpackage

// File: rtl/addsub_block_accum.sv
// Collects fixed-length blocks of unsigned add/sub results and hands out one
// registered sum/min/max summary per block over a valid/ready handshake.
module addsub_block_accum
    import addsub_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BLOCK_LEN = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [DATA_W-1:0]                     in_data_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [DATA_W+$clog2(BLOCK_LEN)-1:0]   out_sum_o,
    output logic [DATA_W-1:0]                     out_min_o,
    output logic [DATA_W-1:0]                     out_max_o,
    output logic                                  busy_o
);

    localparam int ACC_W = DATA_W + $clog2(BLOCK_LEN);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    accum_state_e      state;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  sumAcc;
    logic [DATA_W-1:0] minAcc;
    logic [DATA_W-1:0] maxAcc;
    logic [ACC_W-1:0]  outSum;
    logic [DATA_W-1:0] outMin;
    logic [DATA_W-1:0] outMax;
    logic              inReady;
    logic              outValid;
    logic              busy;

    logic              accept;
    logic              firstSample;
    logic [ACC_W-1:0]  nextSum;
    logic [DATA_W-1:0] nextMin;
    logic [DATA_W-1:0] nextMax;

    // The first sample of a block seeds the accumulators instead of merging into stale values.
    always_comb begin
        accept      = in_valid_i && inReady;
        firstSample = (count == '0);
        nextSum     = ACC_W'(in_data_i);
        nextMin     = in_data_i;
        nextMax     = in_data_i;
        if (!firstSample) begin
            nextSum = sumAcc + ACC_W'(in_data_i);
            nextMin = (in_data_i < minAcc) ? in_data_i : minAcc;
            nextMax = (in_data_i > maxAcc) ? in_data_i : maxAcc;
        end
    end

    // Handshake outputs are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            count    <= '0;
            sumAcc   <= '0;
            minAcc   <= '0;
            maxAcc   <= '0;
            outSum   <= '0;
            outMin   <= '0;
            outMax   <= '0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else if (clear_i) begin
            state    <= S_IDLE;
            count    <= '0;
            sumAcc   <= '0;
            minAcc   <= '0;
            maxAcc   <= '0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        sumAcc <= nextSum;
                        minAcc <= nextMin;
                        maxAcc <= nextMax;
                        busy   <= 1'b1;
                        if (count == LAST_IDX) begin
                            state    <= S_HOLD;
                            count    <= '0;
                            outSum   <= nextSum;
                            outMin   <= nextMin;
                            outMax   <= nextMax;
                            outValid <= 1'b1;
                            inReady  <= 1'b0;
                        end else begin
                            state <= S_ACCUM;
                            count <= count + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready_i) begin
                        state    <= S_IDLE;
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    count    <= '0;
                    outValid <= 1'b0;
                    inReady  <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = inReady;
    assign out_valid_o = outValid;
    assign out_sum_o   = outSum;
    assign out_min_o   = outMin;
    assign out_max_o   = outMax;
    assign busy_o      = busy;

endmodule

// File: tb/tb_addsub_block_accum.sv
// Directed bench for addsub_block_accum with hand-computed block summaries
// (DATA_W = 4, BLOCK_LEN = 4, sum width 6).
module tb_addsub_block_accum;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       inValid;
    logic       inReady;
    logic [3:0] inData;
    logic       outValid;
    logic       outReady;
    logic [5:0] outSum;
    logic [3:0] outMin;
    logic [3:0] outMax;
    logic       busy;

    int checkCount = 0;
    int failCount  = 0;

    addsub_block_accum #(
        .DATA_W   (4),
        .BLOCK_LEN(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .in_data_i  (inData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_sum_o  (outSum),
        .out_min_o  (outMin),
        .out_max_o  (outMax),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of input, then settles just after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] data);
        inValid = valid;
        inData  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic feedBlock(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        applyStimulus(1'b1, d0);
        applyStimulus(1'b1, d1);
        applyStimulus(1'b1, d2);
        applyStimulus(1'b1, d3);
        inValid = 1'b0;
    endtask

    task automatic checkSummary(input string tag, input int sum, input int mn, input int mx);
        checkOutput({tag, ".valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".sum"},   32'(outSum),   32'(sum));
        checkOutput({tag, ".min"},   32'(outMin),   32'(mn));
        checkOutput({tag, ".max"},   32'(outMax),   32'(mx));
        checkOutput({tag, ".ready"}, 32'(inReady),  32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        inValid  = 1'b0;
        inData   = 4'd0;
        outReady = 1'b1;
        applyStimulus(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0);
        rst = 1'b0;

        checkOutput("reset.ready", 32'(inReady),  32'd1);
        checkOutput("reset.valid", 32'(outValid), 32'd0);
        checkOutput("reset.busy",  32'(busy),     32'd0);
        checkOutput("reset.sum",   32'(outSum),   32'd0);
        checkOutput("reset.min",   32'(outMin),   32'd0);
        checkOutput("reset.max",   32'(outMax),   32'd0);

        // Basic block: 6, 2, 10, 4 with the consumer always ready.
        applyStimulus(1'b1, 4'd6);
        checkOutput("basic.busy1", 32'(busy), 32'd1);
        applyStimulus(1'b1, 4'd2);
        applyStimulus(1'b1, 4'd10);
        applyStimulus(1'b1, 4'd4);
        inValid = 1'b0;
        checkSummary("basic", 22, 2, 10);
        applyStimulus(1'b0, 4'd0);
        checkOutput("basic.released", 32'(outValid), 32'd0);
        checkOutput("basic.idleReady", 32'(inReady), 32'd1);
        checkOutput("basic.idleBusy", 32'(busy), 32'd0);

        // Backpressure: summary must hold and no sample may enter while held.
        outReady = 1'b0;
        feedBlock(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd9);
            checkSummary("bp.hold", 10, 1, 4);
        end
        outReady = 1'b1;
        applyStimulus(1'b1, 4'd9);
        checkOutput("bp.released", 32'(outValid), 32'd0);
        checkOutput("bp.readyBack", 32'(inReady), 32'd1);
        checkOutput("bp.noSneak", 32'(busy), 32'd0);

        // Full-scale samples: no overflow in the 6-bit sum.
        feedBlock(4'd15, 4'd15, 4'd15, 4'd15);
        checkSummary("full", 60, 15, 15);
        applyStimulus(1'b0, 4'd0);

        // Wrapped subtraction results (2-7 = 11) are plain unsigned values.
        feedBlock(4'd11, 4'd15, 4'd11, 4'd15);
        checkSummary("wrap", 52, 11, 15);
        applyStimulus(1'b0, 4'd0);

        // Clear mid-block drops the partial block and the coincident sample.
        applyStimulus(1'b1, 4'd9);
        applyStimulus(1'b1, 4'd9);
        clear = 1'b1;
        applyStimulus(1'b1, 4'd9);
        clear = 1'b0;
        checkOutput("clear.busy", 32'(busy), 32'd0);
        checkOutput("clear.ready", 32'(inReady), 32'd1);
        checkOutput("clear.valid", 32'(outValid), 32'd0);
        feedBlock(4'd1, 4'd1, 4'd1, 4'd1);
        checkSummary("clear.after", 4, 1, 1);
        applyStimulus(1'b0, 4'd0);

        // Gaps in the input stream keep the partial block intact.
        outReady = 1'b0;
        applyStimulus(1'b1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd12);
            checkOutput("gap.busy", 32'(busy), 32'd1);
            checkOutput("gap.valid", 32'(outValid), 32'd0);
        end
        applyStimulus(1'b1, 4'd5);
        applyStimulus(1'b1, 4'd0);
        applyStimulus(1'b1, 4'd7);
        inValid = 1'b0;
        checkSummary("gap", 15, 0, 7);

        // Reset while holding a summary discards it and zeroes the outputs.
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0);
        rst = 1'b0;
        checkOutput("rstHold.valid", 32'(outValid), 32'd0);
        checkOutput("rstHold.sum",   32'(outSum),   32'd0);
        checkOutput("rstHold.min",   32'(outMin),   32'd0);
        checkOutput("rstHold.max",   32'(outMax),   32'd0);
        checkOutput("rstHold.busy",  32'(busy),     32'd0);
        checkOutput("rstHold.ready", 32'(inReady),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
